fpu_rob_dispatch: RTL and testbench
===================================

Name: fpu_rob_dispatch

Overview:
- Parametrised FPU request dispatcher with a reorder buffer (ROB). It sits between the FPU issue port and NUM_UNITS independent FPU compute units (fma/div/sqrt/cvt/ncomp and future units).
- Routes each request to its selected unit and tags it with a ROB slot id. Collects out-of-order unit responses and retires them strictly in issue order.
- Applies per-request XLEN result formatting (NaN-box, zero-extend, sign-extend) on retirement.

Parameters:
- NUM_LANES, 4, SIMD lanes per request.
- TAGW, 4, width of the opaque upstream tag.
- NUM_UNITS, 5, number of downstream compute units.
- ROB_DEPTH, 8, in-flight request capacity; power of two, ≥2.
- XLEN, 64, output data width; 32 or 64.
- ROBW, log2(ROB_DEPTH), derived: ROB slot id width.
- USELW, log2up(NUM_UNITS), derived: unit select width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  request valid.
- ready_in  out  1  request accepted when valid_in && ready_in.
- tag_in  in  TAGW  request tag.
- unit_sel  in  USELW  target unit index.
- rt_mode  in  2  result format: 00 NaN-box, 01 zero-extend, 11 sign-extend, 10 reserved (treated as 00).
- unit_valid  out  NUM_UNITS  one-hot dispatch valid.
- unit_ready  in  NUM_UNITS  per-unit dispatch ready.
- unit_rob_id  out  ROBW  slot id sent with the dispatch; shared by all units.
- rsp_valid  in  NUM_UNITS  per-unit response valid.
- rsp_ready  out  NUM_UNITS  per-unit response ready; tied high.
- rsp_rob_id  in  NUM_UNITS*ROBW  slot id returned by each unit.
- rsp_result  in  NUM_UNITS*NUM_LANES*32  unit results.
- rsp_has_fflags  in  NUM_UNITS  fflags valid.
- rsp_fflags  in  NUM_UNITS*NUM_LANES*5  per-lane flags.
- valid_out  out  1  retired response valid.
- ready_out  in  1  downstream ready.
- result  out  NUM_LANES*XLEN  formatted result.
- has_fflags  out  1  retired has_fflags.
- fflags  out  NUM_LANES*5  retired flags.
- tag_out  out  TAGW  retired tag.

Behaviour:
- Reset (reset_n low, asynchronous):
  - head, tail and count are 0.
  - All entry valid/done bits are 0.
  - valid_out, has_fflags, result, fflags and tag_out are 0.
  - unit_valid is 0 (combinational from valid_in; masked while in reset).
- ready_in = (count != ROB_DEPTH) && unit_ready[unit_sel]. count is the registered value; there is no same-cycle bypass from retirement.
- unit_valid[unit_sel] = valid_in && (count != ROB_DEPTH). unit_rob_id = tail.
- Allocation on valid_in && ready_in:
  - Entry[tail] receives {valid=1, done=0, tag, rt_mode}.
  - tail increments modulo ROB_DEPTH.
- Responses:
  - Every rsp_valid[u] writes its result, has_fflags and fflags into entry[rsp_rob_id[u]] and sets done=1.
  - Multiple units may write different entries in the same cycle.
  - A write to an entry with valid=0 or done=1 is illegal: the assertion fires and the write is dropped.
- Retirement:
  - When entry[head] has valid && done, and the output register is empty or draining (!valid_out || ready_out), the entry moves into the output register.
  - valid_out is set, the entry is cleared, and head increments.
- Latency:
  - A response written in cycle N to the head entry appears on valid_out in cycle N+1.
  - An allocation in cycle N can produce a unit response in N+1 at the earliest.
  - Throughput is one retirement per cycle with no bubbles.
- Output hold: when valid_out && !ready_out, all outputs hold stable.
- count update: +1 on allocation, −1 on retirement; unchanged when both occur. Simultaneous allocation and retirement at full is impossible, because ready_in is 0 when full.
- Wrap-around: head and tail wrap modulo ROB_DEPTH. Full vs empty is determined by count, not pointer equality.
- Formatting per lane r = rsp_result lane:
  - XLEN=32: pass r through.
  - XLEN=64, mode 00: {32'hFFFFFFFF, r}.
  - XLEN=64, mode 01: {32'h0, r}.
  - XLEN=64, mode 11: sign-extend r.
- Reset mid-operation: all in-flight entries are discarded and no response is emitted. Units are reset in the same domain.

Decomposition:
- Shared package fpu_rob_pkg:
  - rt_mode_t enum (RT_NANBOX=00, RT_ZEXT=01, RT_SEXT=11).
  - FFLAGS_BITS=5.
  - rob_entry_t struct {valid, done, tag, rt_mode, has_fflags, fflags, result}.
- One sub-module, fpu_rob_fmt: per-lane XLEN formatting, combinational, instantiated in the retire path.

Test Plan:
- In-order single request: tag=3, unit 0, mode 00; unit returns 0x3F800000 in the next cycle → valid_out one cycle later, tag_out=3, result lane = 0xFFFFFFFF3F800000.
- Out-of-order responses: issue tags 1, 2, 3 to units 1, 0, 0; unit 0 answers ids 1 and 2 before unit 1 answers id 0 → outputs in tag order 1, 2, 3, on consecutive cycles after id 0 completes.
- Full: ROB_DEPTH=8, 8 requests with no responses → ready_in=0 on the 9th. One retirement → ready_in=1 the following cycle, not the same cycle.
- Backpressure: ready_out=0 for 5 cycles with valid_out=1 → result, tag_out and fflags stable; the next head entry retires in the cycle ready_out rises.
- Format modes, value 0x80000001 → mode 01 gives 0x0000000080000001; mode 11 gives 0xFFFFFFFF80000001; with XLEN=32 both give 0x80000001.
- Reset mid-flight: 4 entries outstanding, assert reset_n=0 asynchronously → valid_out drops immediately, count=0; after release, ready_in=1 and tail=0.

Source files
------------

// File: rtl/fpu_rob_pkg.sv
// fpu_rob_pkg: shared types for the FPU ROB dispatcher (result format modes, ROB entry layout, flag width)
package fpu_rob_pkg;
  localparam int FFLAGS_BITS = 5;
  localparam int ROB_LANES = 4;
  localparam int ROB_TAGW = 4;
  typedef enum logic [1:0] {
    RT_NANBOX = 2'b00,
    RT_ZEXT   = 2'b01,
    RT_SEXT   = 2'b11
  } rt_mode_t;
  typedef struct packed {
    logic                              valid;
    logic                              done;
    logic [ROB_TAGW-1:0]               tag;
    rt_mode_t                          rt_mode;
    logic                              has_fflags;
    logic [ROB_LANES*FFLAGS_BITS-1:0]  fflags;
    logic [ROB_LANES*32-1:0]           result;
  } rob_entry_t;
endpackage

// File: rtl/fpu_rob_fmt.sv
// fpu_rob_fmt: per-lane XLEN result formatting; ports: data_i raw 32-bit lanes, mode_i format, data_o formatted lanes
module fpu_rob_fmt
  import fpu_rob_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 64
) (
  input  logic [NUM_LANES*32-1:0]   data_i,
  input  rt_mode_t                  mode_i,
  output logic [NUM_LANES*XLEN-1:0] data_o
);
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [31:0] r;
    assign r = data_i[l*32 +: 32];
    if (XLEN == 32) begin : g_pass
      assign data_o[l*XLEN +: XLEN] = r;
    end else begin : g_ext
      assign data_o[l*XLEN +: XLEN] = {mode_i == RT_ZEXT ? 32'h0 : mode_i == RT_SEXT ? {32{r[31]}} : 32'hFFFF_FFFF, r};
    end
  end
endmodule

// File: rtl/fpu_rob_dispatch.sv
// fpu_rob_dispatch: routes FPU requests to units with ROB slot ids and retires unit responses in issue order; ports: issue (valid_in/ready_in/tag_in/unit_sel/rt_mode), dispatch (unit_*), responses (rsp_*), retire (valid_out/ready_out/result/has_fflags/fflags/tag_out)
module fpu_rob_dispatch
  import fpu_rob_pkg::*;
#(
  parameter int NUM_LANES = ROB_LANES,
  parameter int TAGW      = ROB_TAGW,
  parameter int NUM_UNITS = 5,
  parameter int ROB_DEPTH = 8,
  parameter int XLEN      = 64,
  localparam int ROBW     = $clog2(ROB_DEPTH),
  localparam int USELW    = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   valid_in,
  output logic                                   ready_in,
  input  logic [TAGW-1:0]                        tag_in,
  input  logic [USELW-1:0]                       unit_sel,
  input  logic [1:0]                             rt_mode,
  output logic [NUM_UNITS-1:0]                   unit_valid,
  input  logic [NUM_UNITS-1:0]                   unit_ready,
  output logic [ROBW-1:0]                        unit_rob_id,
  input  logic [NUM_UNITS-1:0]                   rsp_valid,
  output logic [NUM_UNITS-1:0]                   rsp_ready,
  input  logic [NUM_UNITS*ROBW-1:0]              rsp_rob_id,
  input  logic [NUM_UNITS*NUM_LANES*32-1:0]      rsp_result,
  input  logic [NUM_UNITS-1:0]                   rsp_has_fflags,
  input  logic [NUM_UNITS*NUM_LANES*FFLAGS_BITS-1:0] rsp_fflags,
  output logic                                   valid_out,
  input  logic                                   ready_out,
  output logic [NUM_LANES*XLEN-1:0]              result,
  output logic                                   has_fflags,
  output logic [NUM_LANES*FFLAGS_BITS-1:0]       fflags,
  output logic [TAGW-1:0]                        tag_out
);
  localparam int RW = NUM_LANES*32;
  localparam int FW = NUM_LANES*FFLAGS_BITS;
  rob_entry_t rob_q [ROB_DEPTH];
  rob_entry_t rob_w [ROB_DEPTH];
  rob_entry_t rob_d [ROB_DEPTH];
  rob_entry_t head_e;
  logic [ROBW:0] count_q, count_d;
  logic [ROBW-1:0] head_q, head_d, tail_q, tail_d;
  logic [NUM_UNITS-1:0] rsp_ok;
  logic full, sel_ok, alloc, retire;
  logic vout_q, vout_d, hf_q, hf_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [FW-1:0] ff_q, ff_d;
  logic [NUM_LANES*XLEN-1:0] res_q, res_d, res_fmt;
  assign full = count_q == (ROBW+1)'(ROB_DEPTH);
  assign sel_ok = {1'b0, unit_sel} < (USELW+1)'(NUM_UNITS);
  assign ready_in = !full && sel_ok && unit_ready[unit_sel];
  assign unit_valid = (reset_n && valid_in && !full && sel_ok) ? NUM_UNITS'(1) << unit_sel : '0;
  assign unit_rob_id = tail_q;
  assign rsp_ready = '1;
  assign alloc = valid_in && ready_in;
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_rsp
    assign rsp_ok[u] = rob_q[rsp_rob_id[u*ROBW +: ROBW]].valid && !rob_q[rsp_rob_id[u*ROBW +: ROBW]].done;
    a_rsp_legal : assert property (@(posedge clk) disable iff (!reset_n) rsp_valid[u] |-> rsp_ok[u]);
  end
  // responses land first so a head completion can retire in the same cycle
  always_comb begin
    rob_w = rob_q;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (rsp_valid[u] && rsp_ok[u]) begin
        rob_w[rsp_rob_id[u*ROBW +: ROBW]].done = 1'b1;
        rob_w[rsp_rob_id[u*ROBW +: ROBW]].result = rsp_result[u*RW +: RW];
        rob_w[rsp_rob_id[u*ROBW +: ROBW]].has_fflags = rsp_has_fflags[u];
        rob_w[rsp_rob_id[u*ROBW +: ROBW]].fflags = rsp_fflags[u*FW +: FW];
      end
    end
  end
  assign head_e = rob_w[head_q];
  assign retire = head_e.valid && head_e.done && (!vout_q || ready_out);
  fpu_rob_fmt #(.NUM_LANES(NUM_LANES), .XLEN(XLEN)) u_fmt (
    .data_i (head_e.result),
    .mode_i (head_e.rt_mode),
    .data_o (res_fmt)
  );
  always_comb begin
    rob_d = rob_w;
    if (retire) rob_d[head_q] = '0;
    if (alloc) rob_d[tail_q] = '{valid: 1'b1, done: 1'b0, tag: tag_in, rt_mode: rt_mode_t'(rt_mode), default: '0};
    head_d = head_q + ROBW'(retire);
    tail_d = tail_q + ROBW'(alloc);
    count_d = count_q + (ROBW+1)'(alloc) - (ROBW+1)'(retire);
    vout_d = retire || (vout_q && !ready_out);
    tag_d = retire ? head_e.tag : tag_q;
    hf_d = retire ? head_e.has_fflags : hf_q;
    ff_d = retire ? head_e.fflags : ff_q;
    res_d = retire ? res_fmt : res_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      vout_q <= 1'b0;
      tag_q <= '0;
      hf_q <= 1'b0;
      ff_q <= '0;
      res_q <= '0;
    end else begin
      rob_q <= rob_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      vout_q <= vout_d;
      tag_q <= tag_d;
      hf_q <= hf_d;
      ff_q <= ff_d;
      res_q <= res_d;
    end
  end
  assign valid_out = vout_q;
  assign tag_out = tag_q;
  assign has_fflags = hf_q;
  assign fflags = ff_q;
  assign result = res_q;
endmodule

// File: tb/tb_fpu_rob_dispatch.sv
// tb_fpu_rob_dispatch: directed and randomized checks of the ROB dispatcher against an issue-order reference model
module tb_fpu_rob_dispatch;
  import fpu_rob_pkg::*;
  localparam int NU = 5;
  localparam int NL = 4;
  localparam int D = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, valid_in, ready_in, ready_out, valid_out, has_fflags;
  logic [3:0] tag_in, tag_out;
  logic [2:0] unit_sel, unit_rob_id;
  logic [1:0] rt_mode;
  logic [NU-1:0] unit_valid, unit_ready, rsp_valid, rsp_ready, rsp_has_fflags;
  logic [NU*3-1:0] rsp_rob_id;
  logic [NU*NL*32-1:0] rsp_result;
  logic [NU*NL*5-1:0] rsp_fflags;
  logic [NL*64-1:0] result;
  logic [NL*5-1:0] fflags;
  logic [127:0] f32_in, f32_out;
  rt_mode_t f32_mode;
  fpu_rob_dispatch dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in), .tag_in(tag_in),
    .unit_sel(unit_sel), .rt_mode(rt_mode), .unit_valid(unit_valid), .unit_ready(unit_ready),
    .unit_rob_id(unit_rob_id), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rob_id(rsp_rob_id),
    .rsp_result(rsp_result), .rsp_has_fflags(rsp_has_fflags), .rsp_fflags(rsp_fflags),
    .valid_out(valid_out), .ready_out(ready_out), .result(result), .has_fflags(has_fflags),
    .fflags(fflags), .tag_out(tag_out)
  );
  fpu_rob_fmt #(.NUM_LANES(4), .XLEN(32)) u_fmt32 (.data_i(f32_in), .mode_i(f32_mode), .data_o(f32_out));
  int checks = 0;
  int errors = 0;
  typedef struct {int slot; int unit;} pend_t;
  pend_t pend[$];
  int rob_list[$];
  int tail_m = 0;
  logic [3:0] tag_m [D];
  logic [1:0] mode_m [D];
  bit done_m [D];
  logic [127:0] res_m [D];
  logic hf_m [D];
  logic [19:0] ff_m [D];
  bit out_full = 0;
  logic [3:0] out_tag;
  logic [255:0] out_res;
  logic out_hf;
  logic [19:0] out_ff;
  int plan [NU];
  logic [127:0] drv_res [NU];
  logic drv_hf [NU];
  logic [19:0] drv_ff [NU];
  bit rand_rsp = 0;
  logic r;
  int a;
  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask
  function automatic logic [255:0] fmt64(input logic [127:0] v, input logic [1:0] m);
    logic [255:0] o;
    for (int l = 0; l < 4; l++)
      o[l*64 +: 64] = {m == 2'b01 ? 32'h0 : m == 2'b11 ? {32{v[l*32+31]}} : 32'hFFFF_FFFF, v[l*32 +: 32]};
    return o;
  endfunction
  task automatic step(input bit v, input int sel, input logic [3:0] tg, input logic [1:0] md,
                      input logic [NU-1:0] ur, input bit ro, output logic rdy_obs);
    bit rdy;
    int s;
    int idx[$];
    chk("valid_out", valid_out, out_full);
    if (out_full) begin
      chk("tag_out", tag_out, out_tag);
      chk("result", result, out_res);
      chk("has_fflags", has_fflags, out_hf);
      chk("fflags", fflags, out_ff);
    end
    if (rand_rsp) begin
      for (int u = 0; u < NU; u++) begin
        idx.delete();
        for (int i = 0; i < pend.size(); i++) if (pend[i].unit == u) idx.push_back(i);
        if (idx.size() > 0 && $urandom_range(1) == 1) begin
          plan[u] = pend[idx[$urandom_range(idx.size()-1)]].slot;
          drv_res[u] = {$urandom, $urandom, $urandom, $urandom};
          drv_hf[u] = 1'($urandom);
          drv_ff[u] = 20'($urandom);
        end
      end
    end
    valid_in = v;
    unit_sel = 3'(sel);
    tag_in = tg;
    rt_mode = md;
    unit_ready = ur;
    ready_out = ro;
    for (int u = 0; u < NU; u++) begin
      rsp_valid[u] = plan[u] >= 0;
      rsp_rob_id[u*3 +: 3] = 3'(plan[u]);
      rsp_result[u*128 +: 128] = drv_res[u];
      rsp_has_fflags[u] = drv_hf[u];
      rsp_fflags[u*20 +: 20] = drv_ff[u];
    end
    #1;
    rdy = rob_list.size() != D && ur[sel];
    rdy_obs = ready_in;
    chk("ready_in", ready_in, rdy);
    chk("unit_valid", unit_valid, (v && rob_list.size() != D) ? NU'(1) << sel : NU'(0));
    if (v) chk("unit_rob_id", unit_rob_id, tail_m);
    for (int u = 0; u < NU; u++) begin
      if (plan[u] >= 0) begin
        s = plan[u];
        done_m[s] = 1;
        res_m[s] = drv_res[u];
        hf_m[s] = drv_hf[u];
        ff_m[s] = drv_ff[u];
        for (int i = pend.size()-1; i >= 0; i--) if (pend[i].slot == s) pend.delete(i);
      end
    end
    if (ro) out_full = 0;
    if (!out_full && rob_list.size() > 0 && done_m[rob_list[0]]) begin
      s = rob_list.pop_front();
      out_full = 1;
      out_tag = tag_m[s];
      out_res = fmt64(res_m[s], mode_m[s]);
      out_hf = hf_m[s];
      out_ff = ff_m[s];
    end
    if (v && rdy) begin
      rob_list.push_back(tail_m);
      tag_m[tail_m] = tg;
      mode_m[tail_m] = md;
      done_m[tail_m] = 0;
      pend.push_back('{tail_m, sel});
      tail_m = (tail_m + 1) % D;
    end
    for (int u = 0; u < NU; u++) plan[u] = -1;
    @(negedge clk);
  endtask
  task automatic drain();
    int n = 0;
    logic rd;
    rand_rsp = 1;
    while ((rob_list.size() > 0 || out_full) && n < 300) begin
      step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, rd);
      n++;
    end
    rand_rsp = 0;
    chk("drain_count", dut.count_q, 0);
    chk("drain_valid_out", valid_out, 0);
  endtask
  initial begin
    for (int u = 0; u < NU; u++) begin
      plan[u] = -1;
      drv_res[u] = '0;
      drv_hf[u] = 1'b0;
      drv_ff[u] = '0;
    end
    reset_n = 1'b0;
    valid_in = 1'b1;
    unit_sel = 3'd0;
    tag_in = '0;
    rt_mode = 2'b00;
    unit_ready = '1;
    ready_out = 1'b1;
    rsp_valid = '0;
    rsp_rob_id = '0;
    rsp_result = '0;
    rsp_has_fflags = '0;
    rsp_fflags = '0;
    f32_in = '0;
    f32_mode = RT_NANBOX;
    #12;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_result", result, 0);
    chk("rst_tag_out", tag_out, 0);
    chk("rst_has_fflags", has_fflags, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_unit_valid", unit_valid, 0);
    chk("rst_count", dut.count_q, 0);
    @(negedge clk);
    reset_n = 1'b1;
    valid_in = 1'b0;
    // single in-order request
    step(1'b1, 0, 4'd3, 2'b00, '1, 1'b1, r);
    plan[0] = 0;
    drv_res[0] = 128'h3F80_0000;
    drv_hf[0] = 1'b0;
    drv_ff[0] = '0;
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    chk("t1_valid", valid_out, 1);
    chk("t1_tag", tag_out, 4'd3);
    chk("t1_lane0", result[63:0], 64'hFFFF_FFFF_3F80_0000);
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    // out-of-order completion, in-order retirement (slots 1,2,3)
    step(1'b1, 1, 4'd1, 2'b00, '1, 1'b1, r);
    step(1'b1, 0, 4'd2, 2'b01, '1, 1'b1, r);
    step(1'b1, 0, 4'd3, 2'b11, '1, 1'b1, r);
    plan[0] = 2;
    drv_res[0] = {$urandom, $urandom, $urandom, $urandom};
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    plan[0] = 3;
    drv_res[0] = {$urandom, $urandom, $urandom, $urandom};
    drv_hf[0] = 1'b1;
    drv_ff[0] = 20'h1F;
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    chk("t2_wait", valid_out, 0);
    plan[1] = 1;
    drv_res[1] = {$urandom, $urandom, $urandom, $urandom};
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    chk("t2_tag1", tag_out, 4'd1);
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    chk("t2_tag2", tag_out, 4'd2);
    chk("t2_v2", valid_out, 1);
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    chk("t2_tag3", tag_out, 4'd3);
    chk("t2_v3", valid_out, 1);
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    // fill to capacity, no bypass of ready_in from retirement
    for (int i = 0; i < D; i++) step(1'b1, 2, 4'(i), 2'b00, '1, 1'b1, r);
    step(1'b1, 2, 4'd8, 2'b00, '1, 1'b1, r);
    chk("t3_full_ready", r, 0);
    plan[2] = 4;
    step(1'b1, 2, 4'd9, 2'b00, '1, 1'b1, r);
    chk("t3_same_cycle_ready", r, 0);
    step(1'b1, 2, 4'd9, 2'b00, '1, 1'b1, r);
    chk("t3_next_cycle_ready", r, 1);
    drain();
    // backpressure hold
    a = tail_m;
    step(1'b1, 3, 4'hA, 2'b00, '1, 1'b0, r);
    step(1'b1, 4, 4'hB, 2'b11, '1, 1'b0, r);
    plan[3] = a;
    plan[4] = (a + 1) % D;
    drv_res[3] = {$urandom, $urandom, $urandom, $urandom};
    drv_res[4] = {$urandom, $urandom, $urandom, $urandom};
    drv_ff[3] = 20'($urandom);
    drv_hf[3] = 1'b1;
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b0, r);
    chk("t4_first", tag_out, 4'hA);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 0, 4'd0, 2'b00, '1, 1'b0, r);
      chk("t4_hold_tag", tag_out, 4'hA);
    end
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    chk("t4_next_tag", tag_out, 4'hB);
    chk("t4_next_valid", valid_out, 1);
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    // format modes
    a = tail_m;
    step(1'b1, 0, 4'd5, 2'b01, '1, 1'b1, r);
    step(1'b1, 1, 4'd6, 2'b11, '1, 1'b1, r);
    plan[0] = a;
    plan[1] = (a + 1) % D;
    drv_res[0] = {$urandom, $urandom, $urandom, 32'h8000_0001};
    drv_res[1] = {$urandom, $urandom, $urandom, 32'h8000_0001};
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    chk("t5_zext", result[63:0], 64'h0000_0000_8000_0001);
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    chk("t5_sext", result[63:0], 64'hFFFF_FFFF_8000_0001);
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b1, r);
    f32_in = {4{32'h8000_0001}};
    f32_mode = RT_ZEXT;
    #1;
    chk("t5_x32_zext", f32_out, {4{32'h8000_0001}});
    f32_mode = RT_SEXT;
    #1;
    chk("t5_x32_sext", f32_out, {4{32'h8000_0001}});
    // asynchronous reset with work in flight
    a = tail_m;
    for (int i = 0; i < 4; i++) step(1'b1, i, 4'(i + 1), 2'b00, '1, 1'b0, r);
    plan[0] = a;
    step(1'b0, 0, 4'd0, 2'b00, '1, 1'b0, r);
    chk("t6_pre_valid", valid_out, 1);
    valid_in = 1'b1;
    unit_sel = 3'd0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_valid_out", valid_out, 0);
    chk("t6_count", dut.count_q, 0);
    chk("t6_unit_valid", unit_valid, 0);
    valid_in = 1'b0;
    rsp_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rob_list.delete();
    pend.delete();
    out_full = 0;
    tail_m = 0;
    chk("t6_tail", dut.tail_q, 0);
    step(1'b1, 0, 4'd7, 2'b00, '1, 1'b1, r);
    chk("t6_ready", r, 1);
    drain();
    // randomized traffic
    rand_rsp = 1;
    for (int i = 0; i < 600; i++)
      step($urandom_range(3) != 0, $urandom_range(NU-1), 4'($urandom), 2'($urandom), NU'($urandom), $urandom_range(3) != 0, r);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
